// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state and forwarding-mux select encodings.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        FREEZE = 2'b01
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: stall/flush/bubble selects, forwarding, dmem freeze.
// Build option: define HAZARD_FWD_EN to enable EX-stage forwarding and load-use-only stalls.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_MEM_WAIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  ex_reg_wr,
    input  logic                  mem_reg_wr,
    input  logic                  wb_reg_wr,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_bubble,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      freeze_cnt
);

    localparam int unsigned WAIT_W = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    hz_state_t         state_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q;
    logic              freeze, branch_flush, data_stall, raw_hit;

    // x0 is hardwired zero, so it never creates a dependency.
    function automatic logic src_match(input logic used, input logic [REG_ADDR_W-1:0] src,
                                       input logic wr, input logic [REG_ADDR_W-1:0] rd);
        return used && (src != '0) && wr && (rd == src);
    endfunction

    function automatic fwd_sel_t fwd_pick(input logic [REG_ADDR_W-1:0] src,
                                          input logic m_wr, input logic [REG_ADDR_W-1:0] m_rd,
                                          input logic w_wr, input logic [REG_ADDR_W-1:0] w_rd);
        if (src == '0)                  return FWD_RF;
        else if (m_wr && (m_rd == src)) return FWD_MEM;
        else if (w_wr && (w_rd == src)) return FWD_WB;
        else                            return FWD_RF;
    endfunction

`ifdef HAZARD_FWD_EN
    assign raw_hit = ex_mem_read &&
                     (src_match(id_rs1_used, id_rs1, ex_reg_wr, ex_rd) ||
                      src_match(id_rs2_used, id_rs2, ex_reg_wr, ex_rd));
    assign fwd_a_sel = rst ? FWD_RF : fwd_pick(ex_rs1, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd);
    assign fwd_b_sel = rst ? FWD_RF : fwd_pick(ex_rs2, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd);
`else
    // No regfile write bypass: a dependency on any in-flight writer stalls until it retires.
    assign raw_hit = src_match(id_rs1_used, id_rs1, ex_reg_wr,  ex_rd)  ||
                     src_match(id_rs1_used, id_rs1, mem_reg_wr, mem_rd) ||
                     src_match(id_rs1_used, id_rs1, wb_reg_wr,  wb_rd)  ||
                     src_match(id_rs2_used, id_rs2, ex_reg_wr,  ex_rd)  ||
                     src_match(id_rs2_used, id_rs2, mem_reg_wr, mem_rd) ||
                     src_match(id_rs2_used, id_rs2, wb_reg_wr,  wb_rd);
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;

    logic unused_fwd;
    assign unused_fwd = ^{ex_rs1, ex_rs2, ex_mem_read,
                          fwd_pick(ex_rs1, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd)};
`endif

    always_comb begin
        freeze = 1'b0;
        if (!rst) begin
            if (state_q == FREEZE) freeze = !dmem_ready;
            else                   freeze = dmem_req && !dmem_ready;
        end
    end

    assign branch_flush = !rst && !freeze && ex_branch_taken;
    assign data_stall   = !rst && !freeze && !ex_branch_taken && raw_hit;

    assign pc_stall      = freeze || data_stall;
    assign if_id_stall   = freeze || data_stall;
    assign if_id_flush   = branch_flush;
    assign id_ex_stall   = freeze;
    assign id_ex_bubble  = branch_flush || data_stall;
    assign ex_mem_stall  = freeze;
    assign mem_wb_bubble = freeze;
    assign mem_timeout   = timeout_q;

    always_comb begin
        wait_d = '0;
        if (freeze) begin
            if (state_q == RUN)         wait_d = WAIT_ONE;
            else if (wait_q == WAIT_MAX) wait_d = wait_q;
            else                        wait_d = wait_q + WAIT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= freeze ? FREEZE : RUN;
            wait_q  <= wait_d;
            if (freeze && (wait_d == WAIT_MAX)) timeout_q <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (data_stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_flush),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze),
        .count (freeze_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit; honours HAZARD_FWD_EN the same way as the design.
module tb_hazard_ctrl_unit;

    localparam longint CNT_MAX = 64'd4294967295;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_rs1_used, id_rs2_used, ex_reg_wr, mem_reg_wr, wb_reg_wr;
    logic       ex_mem_read, ex_branch_taken, dmem_req, dmem_ready;

    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;
    logic        ex_mem_stall, mem_wb_bubble, mem_timeout;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt, freeze_cnt;

    logic        to_pc_stall, to_if_id_stall, to_if_id_flush, to_id_ex_stall, to_id_ex_bubble;
    logic        to_ex_mem_stall, to_mem_wb_bubble, to_mem_timeout;
    logic [1:0]  to_fwd_a_sel, to_fwd_b_sel;
    logic [31:0] to_stall_cnt, to_flush_cnt, to_freeze_cnt;

    logic [6:0] ctrl, to_ctrl;
    assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
                   ex_mem_stall, mem_wb_bubble};
    assign to_ctrl = {to_pc_stall, to_if_id_stall, to_if_id_flush, to_id_ex_stall,
                      to_id_ex_bubble, to_ex_mem_stall, to_mem_wb_bubble};

    hazard_ctrl_unit dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_wr(ex_reg_wr), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
        .mem_wb_bubble(mem_wb_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .freeze_cnt(freeze_cnt)
    );

    // Second instance with a short wait limit to exercise the timeout.
    hazard_ctrl_unit #(.MAX_MEM_WAIT(4)) dut_to (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_wr(ex_reg_wr), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(to_pc_stall), .if_id_stall(to_if_id_stall), .if_id_flush(to_if_id_flush),
        .id_ex_stall(to_id_ex_stall), .id_ex_bubble(to_id_ex_bubble),
        .ex_mem_stall(to_ex_mem_stall), .mem_wb_bubble(to_mem_wb_bubble),
        .fwd_a_sel(to_fwd_a_sel), .fwd_b_sel(to_fwd_b_sel), .mem_timeout(to_mem_timeout),
        .stall_cnt(to_stall_cnt), .flush_cnt(to_flush_cnt), .freeze_cnt(to_freeze_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frozen flag, length of the current freeze run, sticky timeouts, counts.
    bit     m_frozen, m_to, m_to4;
    int     m_run;
    longint m_stall, m_flush, m_freeze;
    bit     e_freeze, e_branch, e_dstall;
    logic [6:0] e_ctrl;
    logic [1:0] e_fwd_a, e_fwd_b;

    function automatic bit dep(input bit used, input logic [4:0] r);
        if (!used || r == 5'd0) return 1'b0;
`ifdef HAZARD_FWD_EN
        return ex_mem_read && ex_reg_wr && (ex_rd == r);
`else
        return (ex_reg_wr && ex_rd == r) || (mem_reg_wr && mem_rd == r) ||
               (wb_reg_wr && wb_rd == r);
`endif
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] r);
`ifdef HAZARD_FWD_EN
        if (r == 5'd0) return 2'b00;
        if (mem_reg_wr && mem_rd == r) return 2'b01;
        if (wb_reg_wr && wb_rd == r) return 2'b10;
`endif
        return 2'b00;
    endfunction

    task automatic model_eval();
        e_freeze = !rst && (m_frozen ? !dmem_ready : (dmem_req && !dmem_ready));
        e_branch = !rst && !e_freeze && ex_branch_taken;
        e_dstall = !rst && !e_freeze && !ex_branch_taken &&
                   (dep(id_rs1_used, id_rs1) || dep(id_rs2_used, id_rs2));
        e_ctrl = {e_freeze || e_dstall, e_freeze || e_dstall, e_branch, e_freeze,
                  e_branch || e_dstall, e_freeze, e_freeze};
        e_fwd_a = rst ? 2'b00 : fwd_of(ex_rs1);
        e_fwd_b = rst ? 2'b00 : fwd_of(ex_rs2);
    endtask

    task automatic tick();
        model_eval();
        if (rst) begin
            m_frozen = 0; m_run = 0; m_to = 0; m_to4 = 0;
            m_stall = 0; m_flush = 0; m_freeze = 0;
        end else begin
            m_run = e_freeze ? m_run + 1 : 0;
            m_frozen = e_freeze;
            if (m_run >= 255) m_to = 1;
            if (m_run >= 4) m_to4 = 1;
            if (e_dstall && m_stall < CNT_MAX) m_stall++;
            if (e_branch && m_flush < CNT_MAX) m_flush++;
            if (e_freeze && m_freeze < CNT_MAX) m_freeze++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_rs1_used, id_rs2_used, ex_reg_wr, mem_reg_wr, wb_reg_wr} = '0;
        {ex_mem_read, ex_branch_taken, dmem_req, dmem_ready} = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        dmem_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_wr = 1'b1;
        id_rs1 = 5'd3; id_rs1_used = 1'b1; ex_rd = 5'd3; ex_reg_wr = 1'b1; ex_mem_read = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({ctrl, fwd_a_sel, fwd_b_sel} !== 11'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got %b, want 0", i, {ctrl, fwd_a_sel, fwd_b_sel});
            end
            tick();
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (ctrl !== 7'd0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_run_state: ctrl=%b timeout=%b, want 0/0", ctrl, mem_timeout);
        end
        checks++;
        if ({stall_cnt, flush_cnt, freeze_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL reset_counters: %0d %0d %0d, want 0 0 0", stall_cnt, flush_cnt, freeze_cnt);
        end
        tick();
    endtask

    task automatic test_data_stall();
        do_reset();
`ifdef HAZARD_FWD_EN
        ex_rd = 5'd5; ex_reg_wr = 1'b1; ex_mem_read = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== 7'b1100100) begin
            errors++;
            $display("FAIL load_use_stall: got %b, want 1100100", ctrl);
        end
        tick();
        ex_rd = 5'd0; ex_reg_wr = 1'b0; ex_mem_read = 1'b0; mem_rd = 5'd5; mem_reg_wr = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== 7'd0) begin
            errors++;
            $display("FAIL load_use_release: got %b, want 0", ctrl);
        end
        tick();
        id_rs1 = 5'd0; id_rs1_used = 1'b0; ex_rs1 = 5'd5; mem_rd = 5'd0; mem_reg_wr = 1'b0;
        wb_rd = 5'd5; wb_reg_wr = 1'b1;
        @(negedge clk);
        checks++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
            errors++;
            $display("FAIL fwd_wb: got a=%b b=%b, want 10/00", fwd_a_sel, fwd_b_sel);
        end
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL load_use_count: got %0d, want 1", stall_cnt);
        end
        tick();
        ex_rs2 = 5'd5; mem_rd = 5'd5; mem_reg_wr = 1'b1;
        @(negedge clk);
        checks++;
        if (fwd_b_sel !== 2'b01) begin
            errors++;
            $display("FAIL fwd_mem_priority: got %b, want 01", fwd_b_sel);
        end
        tick();
`else
        id_rs2 = 5'd7; id_rs2_used = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ex_reg_wr  = (k == 0); ex_rd  = (k == 0) ? 5'd7 : 5'd0;
            mem_reg_wr = (k == 1); mem_rd = (k == 1) ? 5'd7 : 5'd0;
            wb_reg_wr  = (k == 2); wb_rd  = (k == 2) ? 5'd7 : 5'd0;
            @(negedge clk);
            checks++;
            if (ctrl !== ((k < 3) ? 7'b1100100 : 7'd0) || fwd_b_sel !== 2'b00) begin
                errors++;
                $display("FAIL raw_stall cyc%0d: got %b fwd=%b, want stall=%0d", k, ctrl, fwd_b_sel,
                         (k < 3));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL raw_count: got %0d, want 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_branch();
        do_reset();
        ex_branch_taken = 1'b1;
        ex_rd = 5'd4; ex_reg_wr = 1'b1; ex_mem_read = 1'b1; id_rs1 = 5'd4; id_rs1_used = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== 7'b0010100) begin
            errors++;
            $display("FAIL branch_flush: got %b, want 0010100", ctrl);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL branch_counts: flush=%0d stall=%0d, want 1/0", flush_cnt, stall_cnt);
        end
        tick();
    endtask

    task automatic test_freeze();
        do_reset();
        dmem_req = 1'b1;
        ex_branch_taken = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dmem_ready = (k == 4);
            @(negedge clk);
            checks++;
            if (ctrl !== ((k < 4) ? 7'b1101011 : 7'b0010100)) begin
                errors++;
                $display("FAIL freeze cyc%0d: got %b, want %b", k, ctrl,
                         (k < 4) ? 7'b1101011 : 7'b0010100);
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if (freeze_cnt !== 32'd4 || flush_cnt !== 32'd1 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL freeze_counts: freeze=%0d flush=%0d to=%b, want 4/1/0", freeze_cnt,
                     flush_cnt, mem_timeout);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (to_mem_timeout !== (k >= 5) || to_ctrl !== 7'b1101011) begin
                errors++;
                $display("FAIL timeout cyc%0d: to=%b ctrl=%b, want %0d/1101011", k, to_mem_timeout,
                         to_ctrl, (k >= 5));
            end
            tick();
        end
        dmem_ready = 1'b1;
        tick();
        // x0 everywhere: no hazard and no forwarding even with writers active.
        idle();
        ex_reg_wr = 1'b1; ex_mem_read = 1'b1; mem_reg_wr = 1'b1; wb_reg_wr = 1'b1;
        id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        @(negedge clk);
        checks++;
        if (to_mem_timeout !== 1'b1 || mem_timeout !== 1'b0 || to_freeze_cnt !== 32'd10) begin
            errors++;
            $display("FAIL timeout_sticky: to=%b main=%b cnt=%0d, want 1/0/10", to_mem_timeout,
                     mem_timeout, to_freeze_cnt);
        end
        checks++;
        if ({ctrl, fwd_a_sel, fwd_b_sel} !== 11'd0) begin
            errors++;
            $display("FAIL x0_no_hazard: got %b, want 0", {ctrl, fwd_a_sel, fwd_b_sel});
        end
        tick();
        do_reset();
        @(negedge clk);
        checks++;
        if (to_mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b, want 0", to_mem_timeout);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
            ex_reg_wr = 1'($urandom_range(0, 1)); mem_reg_wr = 1'($urandom_range(0, 1));
            wb_reg_wr = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            dmem_req = ($urandom_range(0, 3) == 0);
            dmem_ready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            model_eval();
            checks++;
            if (ctrl !== e_ctrl || to_ctrl !== e_ctrl || fwd_a_sel !== e_fwd_a ||
                fwd_b_sel !== e_fwd_b || to_fwd_a_sel !== e_fwd_a || to_fwd_b_sel !== e_fwd_b) begin
                errors++;
                $display("FAIL rand_ctrl n=%0d: ctrl=%b fa=%b fb=%b, want %b %b %b", n, ctrl,
                         fwd_a_sel, fwd_b_sel, e_ctrl, e_fwd_a, e_fwd_b);
            end
            checks++;
            if (stall_cnt !== m_stall[31:0] || flush_cnt !== m_flush[31:0] ||
                freeze_cnt !== m_freeze[31:0] || to_stall_cnt !== m_stall[31:0] ||
                to_flush_cnt !== m_flush[31:0] || to_freeze_cnt !== m_freeze[31:0]) begin
                errors++;
                $display("FAIL rand_counters n=%0d: %0d %0d %0d, want %0d %0d %0d", n, stall_cnt,
                         flush_cnt, freeze_cnt, m_stall, m_flush, m_freeze);
            end
            checks++;
            if (mem_timeout !== m_to || to_mem_timeout !== m_to4) begin
                errors++;
                $display("FAIL rand_timeout n=%0d: %b %b, want %b %b", n, mem_timeout,
                         to_mem_timeout, m_to, m_to4);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        test_reset();
        test_data_stall();
        test_branch();
        test_freeze();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
